// File: rtl/ctrl_regs_pkg.sv
// Shared definitions for the I2C control-register bank: register map, FSM states,
// reset values and small combinational helpers.
package ctrl_regs_pkg;

    localparam logic [3:0] REG_RX_FREQ  = 4'h0;
    localparam logic [3:0] REG_TX_FREQ  = 4'h4;
    localparam logic [3:0] REG_S_RATE   = 4'h8;
    localparam logic [3:0] REG_TX_LEVEL = 4'h9;
    localparam logic [3:0] REG_ID       = 4'hA;

    localparam logic [31:0] RST_FREQ   = 32'h0000_0000;
    localparam logic [23:0] RST_SHADOW = 24'h00_0000;
    localparam logic [7:0]  RST_BYTE   = 8'h00;
    localparam logic [3:0]  RST_PTR    = 4'h0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK
    } i2c_state_t;

    function automatic logic maj3(input logic [2:0] h);
        return (h[0] & h[1]) | (h[1] & h[2]) | (h[0] & h[2]);
    endfunction

    // Byte idx of a 32-bit word, idx 0 being the most significant byte.
    function automatic logic [7:0] freq_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions the raw SCL/SDA pins (2-flop sync + 3-sample majority) and flags
// SCL edges plus START/STOP on the filtered lines.
module i2c_line_filter
    import ctrl_regs_pkg::*;
(
    input  logic clk,
    input  logic _reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync, sda_sync;
    logic [2:0] scl_hist, sda_hist;
    logic       scl_f, sda_f, scl_q, sda_q;

    // Everything resets to the idle-bus level so no edge is seen on release.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= 3'b111;
            sda_hist <= 3'b111;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
            scl_f    <= maj3(scl_hist);
            sda_f    <= maj3(sda_hist);
            scl_q    <= scl_f;
            sda_q    <= sda_f;
        end
    end

    assign sda      = sda_f;
    assign scl_rise = scl_f & ~scl_q;
    assign scl_fall = ~scl_f & scl_q;
    // SCL must be high in both samples, so an SCL edge in the same cycle masks the condition.
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave register bank: decodes host transactions and drives the NCO tuning
// words, sample-rate select and transmit level, with atomic 32-bit commits.
module i2c_slave_regs
    import ctrl_regs_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h36,
    parameter logic [7:0] ID_BYTE  = 8'hA5
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [31:0] rx_freq,
    output logic [31:0] tx_freq,
    output logic [7:0]  s_rate,
    output logic [7:0]  tx_level,
    output logic        upd,
    output i2c_state_t  state_dbg
);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_filter u_filter (
        .clk       (clk),
        ._reset    (_reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_t  state, state_n;
    logic [3:0]  bit_cnt, cnt_n;
    logic [7:0]  shreg, sh_n;
    logic [3:0]  ptr, ptr_n;
    logic        rw, rw_n, mack, mack_n, oe_n, upd_n;
    logic [23:0] rx_sh, tx_sh, rxs_n, txs_n;
    logic [31:0] rx_n, tx_n;
    logic [7:0]  sr_n, lvl_n, rd_byte;
    logic        byte_done;

    assign state_dbg = state;
    assign byte_done = scl_fall && (bit_cnt == 4'd8);

    // Readback always comes from committed registers, never from the shadows.
    always_comb begin
        rd_byte = 8'h00;
        if (ptr[3:2] == REG_RX_FREQ[3:2])      rd_byte = freq_byte(rx_freq, ptr[1:0]);
        else if (ptr[3:2] == REG_TX_FREQ[3:2]) rd_byte = freq_byte(tx_freq, ptr[1:0]);
        else if (ptr == REG_S_RATE)            rd_byte = s_rate;
        else if (ptr == REG_TX_LEVEL)          rd_byte = tx_level;
        else if (ptr == REG_ID)                rd_byte = ID_BYTE;
    end

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        sh_n    = shreg;
        ptr_n   = ptr;
        rw_n    = rw;
        mack_n  = mack;
        oe_n    = sda_oe;
        rx_n    = rx_freq;
        tx_n    = tx_freq;
        sr_n    = s_rate;
        lvl_n   = tx_level;
        rxs_n   = rx_sh;
        txs_n   = tx_sh;
        upd_n   = 1'b0;
        if (stop_det) begin
            state_n = ST_IDLE;
            oe_n    = 1'b0;
            rxs_n   = RST_SHADOW;
            txs_n   = RST_SHADOW;
        end else if (start_det) begin
            state_n = ST_ADDR;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        sh_n  = {shreg[6:0], sda};
                        cnt_n = bit_cnt + 4'd1;
                    end else if (byte_done) begin
                        cnt_n = 4'd0;
                        oe_n  = 1'b1;
                        if (state == ST_ADDR) begin
                            rw_n    = shreg[0];
                            state_n = ST_ADDR_ACK;
                            if (shreg[7:1] != I2C_ADDR) begin
                                oe_n    = 1'b0;
                                state_n = ST_IDLE;
                            end
                        end else if (state == ST_PTR) begin
                            ptr_n   = shreg[3:0];
                            state_n = ST_PTR_ACK;
                        end else begin
                            state_n = ST_WDATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: if (scl_fall) begin
                    cnt_n = 4'd0;
                    oe_n  = 1'b0;
                    if (rw) begin
                        sh_n    = rd_byte;
                        oe_n    = ~rd_byte[7];
                        state_n = ST_RDATA;
                    end else begin
                        state_n = ST_PTR;
                    end
                end
                ST_PTR_ACK: if (scl_fall) begin
                    oe_n    = 1'b0;
                    cnt_n   = 4'd0;
                    state_n = ST_WDATA;
                end
                ST_WDATA_ACK: if (scl_fall) begin
                    oe_n    = 1'b0;
                    cnt_n   = 4'd0;
                    ptr_n   = ptr + 4'd1;
                    state_n = ST_WDATA;
                    // Offsets 0-2 fill the shadow; offset 3 commits the whole word at once.
                    if (ptr[3:2] == REG_RX_FREQ[3:2]) begin
                        case (ptr[1:0])
                            2'd0:    rxs_n[23:16] = shreg;
                            2'd1:    rxs_n[15:8]  = shreg;
                            2'd2:    rxs_n[7:0]   = shreg;
                            default: begin rx_n = {rx_sh, shreg}; upd_n = 1'b1; end
                        endcase
                    end else if (ptr[3:2] == REG_TX_FREQ[3:2]) begin
                        case (ptr[1:0])
                            2'd0:    txs_n[23:16] = shreg;
                            2'd1:    txs_n[15:8]  = shreg;
                            2'd2:    txs_n[7:0]   = shreg;
                            default: begin tx_n = {tx_sh, shreg}; upd_n = 1'b1; end
                        endcase
                    end else if (ptr == REG_S_RATE) begin
                        sr_n  = shreg;
                        upd_n = 1'b1;
                    end else if (ptr == REG_TX_LEVEL) begin
                        lvl_n = shreg;
                        upd_n = 1'b1;
                    end
                end
                ST_RDATA: if (scl_fall) begin
                    if (bit_cnt == 4'd7) begin
                        oe_n    = 1'b0;
                        cnt_n   = 4'd0;
                        ptr_n   = ptr + 4'd1;
                        state_n = ST_RACK;
                    end else begin
                        sh_n  = {shreg[6:0], 1'b0};
                        oe_n  = ~shreg[6];
                        cnt_n = bit_cnt + 4'd1;
                    end
                end
                ST_RACK: begin
                    if (scl_rise) mack_n = ~sda;
                    if (scl_fall) begin
                        if (mack) begin
                            sh_n    = rd_byte;
                            oe_n    = ~rd_byte[7];
                            cnt_n   = 4'd0;
                            state_n = ST_RDATA;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= 4'd0;
            shreg    <= RST_BYTE;
            ptr      <= RST_PTR;
            rw       <= 1'b0;
            mack     <= 1'b0;
            sda_oe   <= 1'b0;
            upd      <= 1'b0;
            rx_freq  <= RST_FREQ;
            tx_freq  <= RST_FREQ;
            s_rate   <= RST_BYTE;
            tx_level <= RST_BYTE;
            rx_sh    <= RST_SHADOW;
            tx_sh    <= RST_SHADOW;
        end else begin
            state    <= state_n;
            bit_cnt  <= cnt_n;
            shreg    <= sh_n;
            ptr      <= ptr_n;
            rw       <= rw_n;
            mack     <= mack_n;
            sda_oe   <= oe_n;
            upd      <= upd_n;
            rx_freq  <= rx_n;
            tx_freq  <= tx_n;
            s_rate   <= sr_n;
            tx_level <= lvl_n;
            rx_sh    <= rxs_n;
            tx_sh    <= txs_n;
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-banged I2C master, transaction-level
// register model, per-cycle output compare and hand-computed expectations.
`timescale 1ns/1ps
module tb_i2c_slave_regs;
    import ctrl_regs_pkg::*;

    localparam int Q = 8;  // clk cycles per quarter SCL period

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic _reset = 1'b0;
    logic scl_in = 1'b1;
    logic m_sda = 1'b1;
    logic sda_in;
    logic sda_oe, upd;
    logic [31:0] rx_freq, tx_freq;
    logic [7:0] s_rate, tx_level;
    i2c_state_t state_dbg;

    always #250 clk = ~clk;
    assign sda_in = m_sda & ~sda_oe;

    i2c_slave_regs #(.I2C_ADDR(7'h36), .ID_BYTE(8'hA5)) dut (
        .clk       (clk),
        ._reset    (_reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .rx_freq   (rx_freq),
        .tx_freq   (tx_freq),
        .s_rate    (s_rate),
        .tx_level  (tx_level),
        .upd       (upd),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] mem [16];
    logic [7:0] sh [8];
    logic [3:0] m_ptr;
    int exp_upd = 0;
    int upd_cnt = 0;
    bit chk_en = 0;
    bit oe_seen = 0;
    logic upd_prev = 1'b0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) sh[i] = 8'h00;
        mem[10] = 8'hA5;
        m_ptr = 4'h0;
    endfunction

    function automatic void model_write(input logic [7:0] d);
        if (m_ptr < 4'd8) begin
            sh[m_ptr[2:0]] = d;
            if (m_ptr[1:0] == 2'd3) begin
                for (int k = 0; k < 4; k++) mem[{m_ptr[3:2], 2'(k)}] = sh[{m_ptr[2], 2'(k)}];
                exp_upd++;
            end
        end else if (m_ptr == 4'd8 || m_ptr == 4'd9) begin
            mem[m_ptr] = d;
            exp_upd++;
        end
        m_ptr = m_ptr + 4'd1;
    endfunction

    function automatic void model_stop();
        for (int i = 0; i < 8; i++) sh[i] = 8'h00;
    endfunction

    // Single compare process: outputs must match the model whenever SCL is high.
    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1;
        if (_reset) begin
            if (upd) begin
                upd_cnt++;
                check("upd_width", {31'd0, upd_prev}, 32'd0);
            end
            upd_prev = upd;
            if (chk_en && scl_in) begin
                check("rx_freq", rx_freq, {mem[0], mem[1], mem[2], mem[3]});
                check("tx_freq", tx_freq, {mem[4], mem[5], mem[6], mem[7]});
                check("s_rate", {24'd0, s_rate}, {24'd0, mem[8]});
                check("tx_level", {24'd0, tx_level}, {24'd0, mem[9]});
                check("upd_count", upd_cnt, exp_upd);
            end
        end else begin
            upd_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; clks(Q);
        scl_in = 1'b1; clks(Q);
        m_sda = 1'b0; clks(Q);
        scl_in = 1'b0; clks(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; clks(Q);
        scl_in = 1'b1; clks(Q);
        m_sda = 1'b1; clks(Q);
        model_stop();
        clks(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; clks(Q);
        scl_in = 1'b1; clks(2 * Q);
        scl_in = 1'b0; clks(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; clks(Q);
        scl_in = 1'b1; clks(Q);
        b = sda_in; clks(Q);
        scl_in = 1'b0; clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string name);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        check(name, {31'd0, ~b}, {31'd0, exp_ack});
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    task automatic wr_ptr(input logic [7:0] p);
        write_byte(8'h6C, 1'b1, "addr_w_ack");
        write_byte(p, 1'b1, "ptr_ack");
        m_ptr = p[3:0];
    endtask

    task automatic wr_data(input logic [7:0] d);
        write_byte(d, 1'b1, "data_ack");
        model_write(d);
    endtask

    task automatic rd_data(input logic ack, output logic [7:0] d);
        exp_q.push_back(mem[m_ptr]);
        m_ptr = m_ptr + 4'd1;
        read_byte(d, ack);
        check("rdata", {24'd0, d}, {24'd0, exp_q.pop_front()});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] r0, r1, r2, r3;
        model_reset();
        clks(5);
        check("rst_rx_freq", rx_freq, 32'h0);
        check("rst_tx_freq", tx_freq, 32'h0);
        check("rst_s_rate", {24'd0, s_rate}, 32'h0);
        check("rst_tx_level", {24'd0, tx_level}, 32'h0);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'h0);
        check("rst_upd", {31'd0, upd}, 32'h0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        _reset = 1'b1;
        clks(10);
        chk_en = 1;

        // rx_freq full word write
        i2c_start(); wr_ptr(8'h00);
        wr_data(8'h12); wr_data(8'h34); wr_data(8'h56); wr_data(8'h78);
        i2c_stop();
        check("t1_rx_freq", rx_freq, 32'h12345678);
        check("t1_upd_cnt", upd_cnt, 1);

        // partial tx_freq write discarded by STOP
        i2c_start(); wr_ptr(8'h04);
        wr_data(8'hAA); wr_data(8'hBB);
        i2c_stop();
        check("t2_tx_freq", tx_freq, 32'h0);
        check("t2_upd_cnt", upd_cnt, 1);

        // byte registers, upper pointer nibble ignored
        i2c_start(); wr_ptr(8'hF8);
        wr_data(8'h03); wr_data(8'h80);
        i2c_stop();
        check("t3_s_rate", {24'd0, s_rate}, 32'h03);
        check("t3_tx_level", {24'd0, tx_level}, 32'h80);
        check("t3_upd_cnt", upd_cnt, 3);

        // pointer write, repeated START, read ID and reserved bytes
        i2c_start(); wr_ptr(8'h0A);
        i2c_start(); write_byte(8'h6D, 1'b1, "addr_r_ack");
        rd_data(1'b1, r0); rd_data(1'b1, r1); rd_data(1'b0, r2);
        i2c_stop();
        check("t4_id", {24'd0, r0}, 32'hA5);
        check("t4_reserved_b", {24'd0, r1}, 32'h00);
        check("t4_reserved_c", {24'd0, r2}, 32'h00);

        // continued read wraps 0x0F -> 0x00
        i2c_start(); write_byte(8'h6D, 1'b1, "addr_r_ack");
        rd_data(1'b1, r0); rd_data(1'b1, r1); rd_data(1'b1, r2); rd_data(1'b0, r3);
        i2c_stop();
        check("t5_reg_f", {24'd0, r2}, 32'h00);
        check("t5_wrap_rx_msb", {24'd0, r3}, 32'h12);

        // wrong address: no ACK, SDA never pulled
        oe_seen = 0;
        i2c_start(); write_byte(8'h6E, 1'b0, "bad_addr_ack");
        i2c_stop();
        check("t6_oe_seen", {31'd0, oe_seen}, 32'h0);
        check("t6_state", 32'(state_dbg), 32'(ST_IDLE));
        check("t6_s_rate", {24'd0, s_rate}, 32'h03);

        // reset asserted during the ACK bit of a data byte
        i2c_start(); wr_ptr(8'h09);
        for (int i = 7; i >= 0; i--) write_bit(1'(8'h55 >> i));
        m_sda = 1'b1; clks(Q);
        scl_in = 1'b1; clks(Q);
        check("t7_ack_before_reset", {31'd0, sda_oe}, 32'h1);
        _reset = 1'b0;
        model_reset();
        #1;
        check("t7_oe_async", {31'd0, sda_oe}, 32'h0);
        check("t7_rx_freq", rx_freq, 32'h0);
        check("t7_s_rate", {24'd0, s_rate}, 32'h0);
        check("t7_tx_level", {24'd0, tx_level}, 32'h0);
        check("t7_state", 32'(state_dbg), 32'(ST_IDLE));
        clks(3);
        scl_in = 1'b0; clks(Q);
        _reset = 1'b1; clks(Q);
        i2c_stop();

        // bus usable after reset
        i2c_start(); wr_ptr(8'h09);
        wr_data(8'h42);
        i2c_stop();
        check("t8_tx_level", {24'd0, tx_level}, 32'h42);
        check("t8_rx_freq", rx_freq, 32'h0);

        // ---------------- final report ----------------
        clks(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
